// File: rtl/mul_pkg.sv
// Shared constants, sizing helpers and FSM state type for the digit-serial CSA resolver.
package mul_pkg;

    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic int unsigned calc_rw(input int unsigned width);
        return width + 3;
    endfunction

    function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
        return (calc_rw(width) + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/csa_digit_add.sv
// One DIGIT-bit slice of the three-operand resolve: a + b + c + carry-in.
module csa_digit_add
    import mul_pkg::*;
#(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic [DIGIT-1:0] c_i,
    input  logic [CW-1:0]    cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic [CW-1:0]    cout_o
);

    localparam int unsigned DW = DIGIT + CW;

    // 3*(2^DIGIT-1)+2 < 2^(DIGIT+2), so two extra bits hold the full digit sum.
    logic [DW-1:0] d;

    assign d      = DW'(a_i) + DW'(b_i) + DW'(c_i) + DW'(cin_i);
    assign sum_o  = d[DIGIT-1:0];
    assign cout_o = d[DW-1:DIGIT];

endmodule

// File: rtl/csa_serial_resolver.sv
// Resolves one 6:3 counter row (s + 2*c1 + 4*c2) into binary, DIGIT result bits per clock.
module csa_serial_resolver
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] c1_in,
    input  logic [WIDTH-1:0] c2_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+2:0] result,
    output logic             busy
);

    localparam int unsigned RW   = calc_rw(WIDTH);
    localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int unsigned PW   = NDIG * DIGIT;
    localparam int unsigned KW   = $clog2(NDIG + 1);

    state_e           state_q;
    logic [PW-1:0]    a_q, b_q, c_q;
    logic [CW-1:0]    carry_q;
    logic [KW-1:0]    k_q;
    logic [RW-1:0]    res_q, res_d;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [DIGIT-1:0] dsum;
    logic [CW-1:0]    cout;
    logic             last_digit;
    logic [RW-1:0]    slot_mask, slot_val;
    int unsigned      shamt;

    assign last_digit = (k_q == KW'(NDIG - 1));

    csa_digit_add #(
        .DIGIT(DIGIT)
    ) u_digit_add (
        .a_i   (a_q[DIGIT-1:0]),
        .b_i   (b_q[DIGIT-1:0]),
        .c_i   (c_q[DIGIT-1:0]),
        .cin_i (carry_q),
        .sum_o (dsum),
        .cout_o(cout)
    );

    // Merge the current digit into slice k; bits shifted past RW fall off.
    always_comb begin
        shamt     = 32'(k_q) * DIGIT;
        slot_mask = RW'({DIGIT{1'b1}}) << shamt;
        slot_val  = RW'(dsum) << shamt;
        res_d     = (res_q & ~slot_mask) | slot_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            carry_q     <= '0;
            k_q         <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= PW'(s_in);
                        b_q        <= PW'(c1_in) << 1;
                        c_q        <= PW'(c2_in) << 2;
                        carry_q    <= '0;
                        k_q        <= '0;
                        res_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    res_q   <= res_d;
                    carry_q <= cout;
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    c_q     <= c_q >> DIGIT;
                    k_q     <= k_q + 1'b1;
                    if (last_digit) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The result always fits in RW bits, so nothing may carry out of the top digit.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == StRun && last_digit) begin
            assert (cout == '0);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = res_q;

endmodule

// File: tb/tb_csa_serial_resolver.sv
// Directed bench for csa_serial_resolver at WIDTH=16, DIGIT=4 (NDIG=5).
module tb_csa_serial_resolver;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] s_in      = '0;
    logic [15:0] c1_in     = '0;
    logic [15:0] c2_in     = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [18:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csa_serial_resolver #(
        .WIDTH(16),
        .DIGIT(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s_in     (s_in),
        .c1_in    (c1_in),
        .c2_in    (c2_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one row, scramble the inputs after acceptance, then wait for out_valid.
    task automatic run_row(input string tag, input logic [15:0] s, input logic [15:0] c1,
                           input logic [15:0] c2, input logic [31:0] exp);
        int n;
        int bc;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        s_in     = s;
        c1_in    = c1;
        c2_in    = c2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s_in     = ~s;
        c1_in    = ~c1;
        c2_in    = ~c2;
        chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        n  = 0;
        bc = 0;
        while (!out_valid && n < 20) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd5);
        chk({tag, " busy_cycles"}, 32'(bc), 32'd5);
        chk({tag, " result"}, 32'(result), exp);
        chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    endtask

    task automatic handshake(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #1;
        chk({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
        chk({tag, " result_kept"}, 32'(result), exp);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst result", 32'(result), 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst in_ready", 32'(in_ready), 32'd1);

        run_row("zero", 16'h0000, 16'h0000, 16'h0000, 32'h00000);
        handshake("zero", 32'h00000);
        run_row("unit", 16'h0001, 16'h0001, 16'h0001, 32'h00007);
        handshake("unit", 32'h00007);
        run_row("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h6FFF9);
        handshake("max", 32'h6FFF9);
        run_row("xcarry", 16'hFFFF, 16'h0001, 16'h0000, 32'h10001);
        handshake("xcarry", 32'h10001);
        run_row("topbit", 16'h0000, 16'h0000, 16'h8000, 32'h20000);
        handshake("topbit", 32'h20000);

        // Backpressure: hold DONE for 10 cycles while offering a new row.
        out_ready = 1'b0;
        run_row("bp", 16'h00AA, 16'h0055, 16'h0003, 32'h00160);
        in_valid = 1'b1;
        s_in     = 16'h1111;
        c1_in    = 16'h2222;
        c2_in    = 16'h3333;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp hold result", 32'(result), 32'h00160);
            chk("bp hold out_valid", 32'(out_valid), 32'd1);
            chk("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        handshake("bp", 32'h00160);
        run_row("after_bp", 16'h0100, 16'h0080, 16'h0040, 32'h00300);
        handshake("after_bp", 32'h00300);

        // Reset asserted during the third RUN cycle.
        s_in     = 16'hFFFF;
        c1_in    = 16'hFFFF;
        c2_in    = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst result", 32'(result), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("postrst no out_valid", 32'(out_valid), 32'd0);
        end
        run_row("postrst", 16'h1234, 16'h0F0F, 16'h00FF, 32'h0344E);
        handshake("postrst", 32'h0344E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
